lfsr_checker: RTL and testbench

Receive-side companion to the loadable LFSR counter. Samples the counter's output word on each enabled cycle, locks onto the pseudo-random sequence, and then predicts every following value. Reports per-sample mismatches and keeps a saturating error count. Used on the bench and in-system to prove that an LFSR stream arrives intact and in order.

---
 rtl/lfsr_checker.sv | 155 +++++++++++++++
 tb/tb_lfsr_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side LFSR stream checker: hunts for a seed, verifies, then flywheels and counts mismatches.
// Optional LFSR_CHK_LOAD_EN: a sample flagged with load reseeds the prediction instead of being checked.
module lfsr_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'hB8),
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] count,
    input  logic             load,
    input  logic             resync,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       dbg_state
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int LC_W = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], ^(w & TAPS)};
    endfunction

    state_t           r_state, w_state_next;
    logic [MC_W-1:0]  r_mcnt, w_mcnt_next, w_mcnt_inc;
    logic [LC_W-1:0]  r_lcnt, w_lcnt_next, w_lcnt_inc;
    logic [WIDTH-1:0] r_expected, w_expected_next;
    logic             r_err, w_err_next, w_err_inc;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_next;
    logic             r_locked;
    logic             w_sample, w_match, w_zero, w_load, w_lock_hit, w_loss_hit;

`ifdef LFSR_CHK_LOAD_EN
    assign w_load = load;
`else
    assign w_load = load & 1'b0;
`endif

    // resync wins over a coincident sample
    assign w_sample   = cen & ~resync;
    assign w_match    = (count == r_expected);
    assign w_zero     = (count == '0);
    assign w_mcnt_inc = r_mcnt + MC_W'(1);
    assign w_lcnt_inc = r_lcnt + LC_W'(1);
    assign w_lock_hit = (w_mcnt_inc == MC_W'(LOCK_CNT));
    assign w_loss_hit = (w_lcnt_inc == LC_W'(LOSS_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= HUNT;
            r_mcnt     <= '0;
            r_lcnt     <= '0;
            r_expected <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mcnt     <= w_mcnt_next;
            r_lcnt     <= w_lcnt_next;
            r_expected <= w_expected_next;
            r_err      <= w_err_next;
            r_err_cnt  <= w_err_cnt_next;
            r_locked   <= (w_state_next == LOCKED);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (resync) begin
            w_state_next = HUNT;
        end else if (cen) begin
            case (r_state)
                HUNT:    if (!w_zero) w_state_next = VERIFY;
                VERIFY: begin
                    if (w_load)       begin if (w_zero) w_state_next = HUNT; end
                    else if (w_match) begin if (w_lock_hit) w_state_next = LOCKED; end
                    else if (w_zero)  w_state_next = HUNT;
                end
                LOCKED: begin
                    if (w_load)                      begin if (w_zero) w_state_next = HUNT; end
                    else if (!w_match && w_loss_hit) w_state_next = HUNT;
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    always_comb begin
        w_mcnt_next     = r_mcnt;
        w_lcnt_next     = r_lcnt;
        w_expected_next = r_expected;
        w_err_next      = 1'b0;
        w_err_inc       = 1'b0;
        if (w_sample) begin
            case (r_state)
                HUNT: begin
                    if (!w_zero) begin
                        w_expected_next = lfsr_next(count);
                        w_mcnt_next     = '0;
                    end
                end
                VERIFY: begin
                    if (w_load) begin
                        if (!w_zero) w_expected_next = lfsr_next(count);
                    end else if (w_match) begin
                        w_mcnt_next     = w_mcnt_inc;
                        w_expected_next = lfsr_next(count);
                        if (w_lock_hit) w_lcnt_next = '0;
                    end else begin
                        w_mcnt_next = '0;
                        if (!w_zero) w_expected_next = lfsr_next(count);
                    end
                end
                LOCKED: begin
                    if (w_load) begin
                        if (!w_zero) w_expected_next = lfsr_next(count);
                    end else if (w_match) begin
                        w_expected_next = lfsr_next(r_expected);
                        w_lcnt_next     = '0;
                    end else begin
                        // flywheel: keep predicting from our own sequence, not the bad sample
                        w_expected_next = lfsr_next(r_expected);
                        w_lcnt_next     = w_lcnt_inc;
                        w_err_next      = 1'b1;
                        w_err_inc       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (clr_err)
            w_err_cnt_next = w_err_inc ? ERR_W'(1) : '0;
        else if (w_err_inc && (r_err_cnt != '1))
            w_err_cnt_next = r_err_cnt + ERR_W'(1);
        else
            w_err_cnt_next = r_err_cnt;
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign expected  = r_expected;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a small-counter instance for saturation.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0, load = 1'b0, resync = 1'b0, clr_err = 1'b0;
    logic [7:0]  count = '0;
    logic        locked, err;
    logic [15:0] err_cnt;
    logic [7:0]  expected;
    logic [1:0]  dbg_state;

    logic        s_cen = 1'b0;
    logic [7:0]  s_count = '0;
    logic        s_locked, s_err;
    logic [1:0]  s_err_cnt;
    logic [7:0]  s_expected;
    logic [1:0]  s_dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .rst(rst), .cen(cen), .count(count), .load(load),
        .resync(resync), .clr_err(clr_err), .locked(locked), .err(err),
        .err_cnt(err_cnt), .expected(expected), .dbg_state(dbg_state)
    );

    lfsr_checker #(.ERR_W(2), .LOSS_CNT(8)) u_sat (
        .clk(clk), .rst(rst), .cen(s_cen), .count(s_count), .load(1'b0),
        .resync(1'b0), .clr_err(1'b0), .locked(s_locked), .err(s_err),
        .err_cnt(s_err_cnt), .expected(s_expected), .dbg_state(s_dbg_state)
    );

    task automatic drive(input logic c, input logic [7:0] v);
        cen = c; count = v;
        @(posedge clk); #1;
        cen = 1'b0;
    endtask

    task automatic s_drive(input logic [7:0] v);
        s_cen = 1'b1; s_count = v;
        @(posedge clk); #1;
        s_cen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic lock_seq();
        drive(1, 8'h01); drive(1, 8'h02); drive(1, 8'h04); drive(1, 8'h08); drive(1, 8'h11);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (expected !== 8'h00) begin failures++; $display("FAIL reset_expected got=%h exp=00", expected); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lock();
        logic [7:0] seq [5];
        logic [7:0] nxt [5];
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        nxt = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        for (int i = 0; i < 5; i++) begin
            drive(1, seq[i]);
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL lock_err[%0d] got=%0b exp=0", i, err); end
            checks++; if (expected !== nxt[i]) begin failures++; $display("FAIL lock_expected[%0d] got=%h exp=%h", i, expected, nxt[i]); end
            checks++; if (locked !== (i == 4)) begin failures++; $display("FAIL lock_locked[%0d] got=%0b exp=%0b", i, locked, (i == 4)); end
        end
        checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL lock_state got=%0d exp=2", dbg_state); end
    endtask

    task automatic test_flywheel();
        drive(1, 8'h00);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL fly_err got=%0b exp=1", err); end
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL fly_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (expected !== 8'h47) begin failures++; $display("FAIL fly_expected got=%h exp=47", expected); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL fly_locked got=%0b exp=1", locked); end
        drive(0, 8'h55);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL idle_err got=%0b exp=0", err); end
        checks++; if (expected !== 8'h47) begin failures++; $display("FAIL idle_expected got=%h exp=47", expected); end
        drive(1, 8'h47);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL fly_match_err got=%0b exp=0", err); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL fly_match_locked got=%0b exp=1", locked); end
        checks++; if (expected !== 8'h8E) begin failures++; $display("FAIL fly_match_expected got=%h exp=8e", expected); end
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL fly_match_err_cnt got=%0d exp=1", err_cnt); end
    endtask

    task automatic test_loss_and_clr();
        logic [7:0] exp_after [3];
        exp_after = '{8'h1C, 8'h38, 8'h71};
        clr_err = 1'b1; drive(0, 8'h00); clr_err = 1'b0;
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL clr_err_cnt got=%0d exp=0", err_cnt); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h00);
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL loss_err[%0d] got=%0b exp=1", i, err); end
            checks++; if (err_cnt !== 16'(i + 1)) begin failures++; $display("FAIL loss_err_cnt[%0d] got=%0d exp=%0d", i, err_cnt, i + 1); end
            checks++; if (locked !== (i < 2)) begin failures++; $display("FAIL loss_locked[%0d] got=%0b exp=%0b", i, locked, (i < 2)); end
            checks++; if (expected !== exp_after[i]) begin failures++; $display("FAIL loss_expected[%0d] got=%h exp=%h", i, expected, exp_after[i]); end
        end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL loss_state got=%0d exp=0", dbg_state); end
        clr_err = 1'b1; drive(0, 8'h00); clr_err = 1'b0;
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL clr2_err_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_hunt_zero_and_resync();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'h00);
            checks++; if (locked !== 1'b0 || err !== 1'b0 || dbg_state !== 2'd0) begin
                failures++; $display("FAIL hunt_zero[%0d] got locked=%0b err=%0b state=%0d exp 0/0/0", i, locked, err, dbg_state);
            end
        end
        lock_seq();
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL relock got=%0b exp=1", locked); end
        resync = 1'b1; drive(1, 8'h23); resync = 1'b0;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL resync_locked got=%0b exp=0", locked); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL resync_state got=%0d exp=0", dbg_state); end
        checks++; if (expected !== 8'h23) begin failures++; $display("FAIL resync_expected got=%h exp=23", expected); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL resync_err got=%0b exp=0", err); end
    endtask

    task automatic test_clr_coincide();
        lock_seq();
        drive(1, 8'h00);
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL co_pre_err_cnt got=%0d exp=1", err_cnt); end
        clr_err = 1'b1; drive(1, 8'h00); clr_err = 1'b0;
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL co_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL co_err got=%0b exp=1", err); end
        drive(1, 8'h8E);
        checks++; if (locked !== 1'b1 || expected !== 8'h1C) begin
            failures++; $display("FAIL co_recover got locked=%0b expected=%h exp 1/1c", locked, expected);
        end
    endtask

    task automatic test_load();
        load = 1'b1; drive(1, 8'h5A); load = 1'b0;
`ifdef LFSR_CHK_LOAD_EN
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL load_err got=%0b exp=0", err); end
        checks++; if (expected !== 8'hB4) begin failures++; $display("FAIL load_expected got=%h exp=b4", expected); end
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL load_err_cnt got=%0d exp=1", err_cnt); end
`else
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL load_err got=%0b exp=1", err); end
        checks++; if (expected !== 8'h38) begin failures++; $display("FAIL load_expected got=%h exp=38", expected); end
        checks++; if (err_cnt !== 16'd2) begin failures++; $display("FAIL load_err_cnt got=%0d exp=2", err_cnt); end
`endif
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL load_locked got=%0b exp=1", locked); end
    endtask

    task automatic test_saturate_async_reset();
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        s_drive(8'h01); s_drive(8'h02); s_drive(8'h04); s_drive(8'h08); s_drive(8'h11);
        checks++; if (s_locked !== 1'b1) begin failures++; $display("FAIL sat_lock got=%0b exp=1", s_locked); end
        for (int i = 0; i < 5; i++) begin
            s_drive(8'h00);
            checks++; if (s_err_cnt !== sat_exp[i] || s_err !== 1'b1 || s_locked !== 1'b1) begin
                failures++; $display("FAIL sat[%0d] got cnt=%0d err=%0b locked=%0b exp %0d/1/1", i, s_err_cnt, s_err, s_locked, sat_exp[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (s_locked !== 1'b0 || s_err !== 1'b0 || s_err_cnt !== 2'd0 || s_expected !== 8'h00) begin
            failures++; $display("FAIL async_rst_sat got locked=%0b err=%0b cnt=%0d expected=%h exp all 0", s_locked, s_err, s_err_cnt, s_expected);
        end
        checks++; if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 16'd0 || expected !== 8'h00) begin
            failures++; $display("FAIL async_rst_main got locked=%0b err=%0b cnt=%0d expected=%h exp all 0", locked, err, err_cnt, expected);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_flywheel();
        test_loss_and_clr();
        test_hunt_zero_and_resync();
        test_clr_coincide();
        test_load();
        test_saturate_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
